// File: rtl/prim_memctl_pkg.sv
// Shared definitions for the 16-bit to 8-bit SRAM memory controller.
//   state_t               controller FSM encoding
//   BS_NONE/BYTE/WORD     byte-select encodings on i_bs
//   WAIT_STATES_MIN/MAX   legal range of the WAIT_STATES parameter
//   bs_is_null()          true when i_bs selects no bytes (00 or 10)
package prim_memctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_BYTE = 2'b01;
  localparam logic [1:0] BS_WORD = 2'b11;

  localparam int unsigned WAIT_STATES_MIN = 1;
  localparam int unsigned WAIT_STATES_MAX = 6;

  // 2'b10 is not a defined access width and is treated like BS_NONE.
  function automatic logic bs_is_null(input logic [1:0] bs);
    return (bs != BS_BYTE) && (bs != BS_WORD);
  endfunction

endpackage

// File: rtl/prim_memctl_if.sv
// Bus bundle between an initiator, the memory controller and an 8-bit SRAM.
//   initiator side : i_req, i_addr, i_dat, i_bs, i_we -> o_dat, o_ack
//   SRAM side      : o_sram_addr, o_sram_dat, o_sram_we_n, o_sram_oe_n -> i_sram_dat
// Modports:
//   slave  - the controller's view
//   master - the environment's view (initiator plus SRAM device)
interface prim_memctl_if;

  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_dat;
  logic [1:0]  i_bs;
  logic        i_we;
  logic [15:0] o_dat;
  logic        o_ack;
  logic [15:0] o_sram_addr;
  logic [7:0]  o_sram_dat;
  logic [7:0]  i_sram_dat;
  logic        o_sram_we_n;
  logic        o_sram_oe_n;

  modport slave (
    input  i_req, i_addr, i_dat, i_bs, i_we, i_sram_dat,
    output o_dat, o_ack, o_sram_addr, o_sram_dat, o_sram_we_n, o_sram_oe_n
  );

  modport master (
    output i_req, i_addr, i_dat, i_bs, i_we, i_sram_dat,
    input  o_dat, o_ack, o_sram_addr, o_sram_dat, o_sram_we_n, o_sram_oe_n
  );

endinterface

// File: rtl/prim_memctl.sv
// Memory controller: serves 8/16-bit accesses from a 16-bit initiator on an
// external 8-bit SRAM. A word access is split into a low-byte phase (LO, at
// addr) and a high-byte phase (HI, at addr+1); each phase lasts
// WAIT_STATES+1 cycles. Completion is signalled by a one-cycle o_ack.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous, active-high reset
//   bus      - prim_memctl_if.slave: initiator request/response and SRAM pins
// Parameter:
//   WAIT_STATES - extra cycles per SRAM byte phase, legal range 1..6
module prim_memctl
  import prim_memctl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic          i_clk,
  input logic          i_reset,
  prim_memctl_if.slave bus
);

  // Value of the phase counter in the last cycle of a LO/HI phase.
  localparam logic [2:0] PHASE_LAST = 3'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [2:0]  phase_q;
  logic [15:0] addr_q;
  logic [7:0]  dat_hi_q;    // low write byte goes straight to o_sram_dat on accept
  logic        word_q;
  logic        we_q;
  logic [7:0]  rd_lo_q;
  logic [15:0] o_dat_q;
  logic [15:0] sram_addr_q;
  logic [7:0]  sram_dat_q;

  logic in_phase;
  logic phase_last;

  assign in_phase   = (state_q == ST_LO) || (state_q == ST_HI);
  assign phase_last = (phase_q == PHASE_LAST);

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.i_req) state_d = bs_is_null(bus.i_bs) ? ST_ACK : ST_LO;
      ST_LO:   if (phase_last) state_d = word_q ? ST_HI : ST_ACK;
      ST_HI:   if (phase_last) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 3'd0;
      addr_q      <= 16'h0000;
      dat_hi_q    <= 8'h00;
      word_q      <= 1'b0;
      we_q        <= 1'b0;
      rd_lo_q     <= 8'h00;
      o_dat_q     <= 16'h0000;
      sram_addr_q <= 16'h0000;
      sram_dat_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;

      // Any state change (including LO->HI) restarts phase timing.
      if (state_d != state_q) begin
        phase_q <= 3'd0;
      end else if (in_phase) begin
        phase_q <= phase_q + 3'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.i_req) begin
            addr_q   <= bus.i_addr;
            dat_hi_q <= bus.i_dat[15:8];
            word_q   <= (bus.i_bs == BS_WORD);
            we_q     <= bus.i_we;
            // SRAM pins are set up at the edge that enters LO so they are
            // valid for the whole first phase.
            if (!bs_is_null(bus.i_bs)) begin
              sram_addr_q <= bus.i_addr;
              if (bus.i_we) sram_dat_q <= bus.i_dat[7:0];
            end
          end
        end
        ST_LO: begin
          if (phase_last) begin
            if (!we_q) begin
              if (word_q) rd_lo_q <= bus.i_sram_dat;
              else        o_dat_q <= {8'h00, bus.i_sram_dat};
            end
            if (word_q) begin
              sram_addr_q <= addr_q + 16'd1;   // wraps 0xFFFF -> 0x0000
              if (we_q) sram_dat_q <= dat_hi_q;
            end
          end
        end
        ST_HI: begin
          if (phase_last && !we_q) o_dat_q <= {bus.i_sram_dat, rd_lo_q};
        end
        default: ;
      endcase
    end
  end

  // Write strobe is low for the first WAIT_STATES cycles of a phase and
  // released in the last cycle so the SRAM latches data before it changes.
  assign bus.o_sram_we_n = !(in_phase && we_q && (phase_q < PHASE_LAST));
  assign bus.o_sram_oe_n = !(in_phase && !we_q);
  assign bus.o_sram_addr = sram_addr_q;
  assign bus.o_sram_dat  = sram_dat_q;
  assign bus.o_dat       = o_dat_q;
  assign bus.o_ack       = (state_q == ST_ACK);

endmodule

// File: tb/tb_prim_memctl.sv
// Self-checking bench for prim_memctl. Two instances (WAIT_STATES 1 and 3)
// share the request inputs; `sel` routes i_req to one of them and picks which
// outputs are observed. Each instance has its own SRAM array, and a
// transaction-level reference model (byte array + expected o_dat) predicts
// latency, strobe counts, read data and memory contents.
module tb_prim_memctl;
  import prim_memctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req;
  logic [15:0] addr;
  logic [15:0] dat;
  logic [1:0]  bs;
  logic        we;
  logic        sel;

  prim_memctl_if bus1 ();
  prim_memctl_if bus3 ();

  assign bus1.i_req  = req & ~sel;
  assign bus1.i_addr = addr;
  assign bus1.i_dat  = dat;
  assign bus1.i_bs   = bs;
  assign bus1.i_we   = we;
  assign bus3.i_req  = req & sel;
  assign bus3.i_addr = addr;
  assign bus3.i_dat  = dat;
  assign bus3.i_bs   = bs;
  assign bus3.i_we   = we;

  prim_memctl #(.WAIT_STATES(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));
  prim_memctl #(.WAIT_STATES(3)) u_dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3));

  // SRAM devices and reference memories, index 0 = WS1 instance, 1 = WS3.
  logic [7:0]  sram_m [2][65536];
  logic [7:0]  ref_m  [2][65536];
  logic [15:0] exp_dat [2];

  // Reads return a marker byte when output enable is not asserted.
  assign bus1.i_sram_dat = bus1.o_sram_oe_n ? 8'h5A : sram_m[0][bus1.o_sram_addr];
  assign bus3.i_sram_dat = bus3.o_sram_oe_n ? 8'h5A : sram_m[1][bus3.o_sram_addr];

  always @(posedge clk) begin
    if (!bus1.o_sram_we_n) sram_m[0][bus1.o_sram_addr] = bus1.o_sram_dat;
    if (!bus3.o_sram_we_n) sram_m[1][bus3.o_sram_addr] = bus3.o_sram_dat;
  end

  logic [15:0] m_dat, m_saddr;
  logic [7:0]  m_sdat;
  logic        m_ack, m_we_n, m_oe_n;

  always_comb begin
    m_dat   = sel ? bus3.o_dat       : bus1.o_dat;
    m_ack   = sel ? bus3.o_ack       : bus1.o_ack;
    m_saddr = sel ? bus3.o_sram_addr : bus1.o_sram_addr;
    m_sdat  = sel ? bus3.o_sram_dat  : bus1.o_sram_dat;
    m_we_n  = sel ? bus3.o_sram_we_n : bus1.o_sram_we_n;
    m_oe_n  = sel ? bus3.o_sram_oe_n : bus1.o_sram_oe_n;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(m_ack),   32'd0);
    check({tag, "_dat"},   32'(m_dat),   32'd0);
    check({tag, "_saddr"}, 32'(m_saddr), 32'd0);
    check({tag, "_sdat"},  32'(m_sdat),  32'd0);
    check({tag, "_we_n"},  32'(m_we_n),  32'd1);
    check({tag, "_oe_n"},  32'(m_oe_n),  32'd1);
  endtask

  // One access on the selected instance. Called at a negedge. With b2b set,
  // the instance is in its ACK cycle (previous call used keep) and the bench
  // expects exactly one IDLE cycle before acceptance. With keep set, i_req
  // stays high after o_ack so the next call continues back-to-back.
  task automatic access(input logic [1:0] t_bs, input logic t_we, input logic [15:0] t_addr,
                        input logic [15:0] t_dat, input bit b2b, input bit keep);
    int k, ws, nb, lat, c, we_lo, oe_lo;
    logic [15:0] a;
    k  = sel ? 1 : 0;
    ws = sel ? 3 : 1;
    nb = (t_bs == BS_WORD) ? 2 : (t_bs == BS_BYTE) ? 1 : 0;
    lat = (nb == 0) ? 1 : nb * (ws + 1) + 1;

    req = 1'b1; bs = t_bs; we = t_we; addr = t_addr; dat = t_dat;
    if (b2b) begin
      @(negedge clk);
      check("idle_gap_ack", 32'(m_ack), 32'd0);
    end
    @(posedge clk);   // acceptance edge
    c = 0; we_lo = 0; oe_lo = 0;
    do begin
      @(negedge clk);
      c++;
      if (!m_we_n) we_lo++;
      if (!m_oe_n) oe_lo++;
      if (!m_ack) begin
        // The controller must ignore inputs while busy.
        addr = 16'($urandom); dat = 16'($urandom); bs = 2'($urandom); we = 1'($urandom);
      end
    end while (!m_ack && c < 40);
    check("latency", 32'(c), 32'(lat));

    for (int i = 0; i < nb; i++) begin
      a = t_addr + 16'(i);
      if (t_we) ref_m[k][a] = t_dat[8*i +: 8];
    end
    if (!t_we && nb == 1) exp_dat[k] = {8'h00, ref_m[k][t_addr]};
    if (!t_we && nb == 2) exp_dat[k] = {ref_m[k][t_addr + 16'd1], ref_m[k][t_addr]};

    check("we_low_cycles", 32'(we_lo), t_we ? 32'(nb * ws) : 32'd0);
    check("oe_low_cycles", 32'(oe_lo), t_we ? 32'd0 : 32'(nb * (ws + 1)));
    check("o_dat", 32'(m_dat), 32'(exp_dat[k]));
    if (t_we) begin
      for (int i = 0; i < nb; i++) begin
        a = t_addr + 16'(i);
        check("sram_byte", 32'(sram_m[k][a]), 32'(ref_m[k][a]));
      end
    end

    if (!keep) begin
      req = 1'b0;
      @(negedge clk);
      check("ack_pulse", 32'(m_ack), 32'd0);
    end
  endtask

  task automatic preset(input int k, input logic [15:0] a, input logic [7:0] v);
    sram_m[k][a] = v;
    ref_m[k][a]  = v;
  endtask

  initial begin
    bit prev_keep;
    bit keep;
    logic [15:0] ra;

    sel = 1'b0; req = 1'b0; addr = '0; dat = '0; bs = BS_NONE; we = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      sram_m[0][i] = 8'(i * 7 + 3);
      sram_m[1][i] = 8'(i * 7 + 3);
      ref_m[0][i]  = 8'(i * 7 + 3);
      ref_m[1][i]  = 8'(i * 7 + 3);
    end
    exp_dat[0] = '0;
    exp_dat[1] = '0;

    #1;
    check_reset_outputs("rst1");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst3");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Byte write, WAIT_STATES=1.
    access(BS_BYTE, 1'b1, 16'h1234, 16'h00AB, 1'b0, 1'b0);
    check("byte_wr_mem", 32'(sram_m[0][16'h1234]), 32'h0000_00AB);
    check("byte_wr_o_dat", 32'(m_dat), 32'h0);

    // Unaligned word read.
    preset(0, 16'h0101, 8'h34);
    preset(0, 16'h0102, 8'h12);
    access(BS_WORD, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0);
    check("word_rd_dat", 32'(m_dat), 32'h0000_1234);

    // Word write across the top of the address space.
    access(BS_WORD, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0, 1'b0);
    check("wrap_lo", 32'(sram_m[0][16'hFFFF]), 32'h0000_00EF);
    check("wrap_hi", 32'(sram_m[0][16'h0000]), 32'h0000_00BE);

    // Null accesses.
    access(2'b00, 1'b1, 16'h4000, 16'h5555, 1'b0, 1'b0);
    access(2'b10, 1'b0, 16'h4000, 16'h5555, 1'b0, 1'b0);
    check("null_o_dat", 32'(m_dat), 32'h0000_1234);

    // Reset during HI of a word write.
    req = 1'b1; bs = BS_WORD; we = 1'b1; addr = 16'h2000; dat = 16'hC3A5;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid_hi_we_n", 32'(m_we_n), 32'd0);
    check("mid_hi_saddr", 32'(m_saddr), 32'h0000_2001);
    check("mid_hi_sdat", 32'(m_sdat), 32'h0000_00C3);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check_reset_outputs("abort");
    ref_m[0][16'h2000] = 8'hA5;
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack", 32'(m_ack), 32'd0);
    end
    rst = 1'b0;
    check("partial_lo", 32'(sram_m[0][16'h2000]), 32'h0000_00A5);
    check("partial_hi", 32'(sram_m[0][16'h2001]), 32'(ref_m[0][16'h2001]));
    access(BS_BYTE, 1'b0, 16'h2000, 16'h0000, 1'b0, 1'b0);
    check("read_after_rst", 32'(m_dat), 32'h0000_00A5);

    // WAIT_STATES=3, two word reads with i_req held high.
    sel = 1'b1;
    preset(1, 16'h0300, 8'h11);
    preset(1, 16'h0301, 8'h22);
    preset(1, 16'h0500, 8'h33);
    preset(1, 16'h0501, 8'h44);
    access(BS_WORD, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b1);
    check("b2b_first", 32'(m_dat), 32'h0000_2211);
    access(BS_WORD, 1'b0, 16'h0500, 16'h0000, 1'b1, 1'b0);
    check("b2b_second", 32'(m_dat), 32'h0000_4433);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      prev_keep = 1'b0;
      for (int n = 0; n < 30; n++) begin
        ra = ($urandom_range(0, 1) != 0 ? 16'hFFF8 : 16'h0040) + 16'($urandom_range(0, 15));
        keep = (n != 29) && ($urandom_range(0, 2) == 0);
        access(2'($urandom), 1'($urandom), ra, 16'($urandom), prev_keep, keep);
        prev_keep = keep;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
